// File: rtl/mc_main_ctrl.sv
// Main control FSM for a multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback,
// stalls on the memory ready handshake, counts retired instructions and flags unsupported opcodes.
module mc_main_ctrl #(
    parameter int CNT_W = 32,
    parameter int ST_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic [1:0]       PCSource,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           r_state;
    logic [5:0]       r_opcode;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             r_illegal;

    state_t           w_next_state;
    logic             w_retire;
    logic             w_illegal_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RST;
            r_instr_cnt <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_illegal <= w_illegal_op;
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    // The opcode is captured in DECODE so MEMADR's lw/sw split ignores later IR changes.
    always_ff @(posedge clk) begin
        if (r_state == S_DECODE) begin
            r_opcode <= opcode;
        end
    end

    always_comb begin
        w_next_state = S_RST;
        w_retire     = 1'b0;
        w_illegal_op = 1'b0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        MemtoReg     = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUop        = 2'b00;
        PCSource     = 2'b00;

        case (r_state)
            S_RST: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                MemRead      = 1'b1;
                ALUSrcB      = 2'b01;
                // PC+4 and IR load only commit on the cycle memory delivers the word.
                IRWrite      = mem_ready;
                PCWrite      = mem_ready;
                w_next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:     w_next_state = S_EXEC;
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_next_state = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead      = 1'b1;
                IorD         = 1'b1;
                w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite     = 1'b1;
                MemtoReg     = 1'b1;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                MemWrite     = 1'b1;
                IorD         = 1'b1;
                w_next_state = mem_ready ? S_FETCH : S_MEMWR;
                w_retire     = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA      = 1'b1;
                ALUop        = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite     = 1'b1;
                RegDst       = 1'b1;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUop        = 2'b01;
                PCWriteCond  = 1'b1;
                PCSource     = 2'b01;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_JUMP: begin
                PCWrite      = 1'b1;
                PCSource     = 2'b10;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite     = 1'b1;
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            default: begin
                w_next_state = S_RST;
            end
        endcase
    end

    assign state     = ST_W'(r_state);
    assign instr_cnt = r_instr_cnt;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: walks each instruction class cycle by cycle against hand-derived
// state and control-word tables, plus reset, illegal opcode and counter wrap scenarios.
module tb_mc_main_ctrl;

    localparam int CNT_W = 4;
    localparam int ST_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUop, PCSource;
    logic [ST_W-1:0]  state;
    logic [CNT_W-1:0] instr_cnt;
    logic             illegal;
    logic [15:0]      ctl;

    int n_checks = 0;
    int n_fail   = 0;

    mc_main_ctrl #(.CNT_W(CNT_W), .ST_W(ST_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource),
        .state(state), .instr_cnt(instr_cnt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Control word: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUop,PCSource
    assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource};

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'h00;
        cyc(); cyc(); #1;
        n_checks++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++;
        if (ctl !== 16'h0000) begin n_fail++; $display("FAIL reset_ctl: got %h expected 0000", ctl); end
        n_checks++;
        if (instr_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", instr_cnt); end
        n_checks++;
        if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
        rst = 1'b0; #1;
        n_checks++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL reset_hold: got %0d expected 0", state); end
        cyc(); #1;
        n_checks++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL reset_to_fetch: got %0d expected 1", state); end
    endtask

    task automatic test_rtype();
        logic [3:0]  exp_st  [0:3];
        logic [15:0] exp_ctl [0:3];
        exp_st  = '{4'd1, 4'd2, 4'd7, 4'd8};
        exp_ctl = '{16'h9410, 16'h0030, 16'h0048, 16'h0180};
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; opcode = 6'h00; #1;
            n_checks++;
            if (state !== exp_st[i]) begin n_fail++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
            n_checks++;
            if (ctl !== exp_ctl[i]) begin n_fail++; $display("FAIL rtype_ctl[%0d]: got %h expected %h", i, ctl, exp_ctl[i]); end
            cyc();
        end
        #1;
        n_checks++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL rtype_end_state: got %0d expected 1", state); end
        n_checks++;
        if (instr_cnt !== 4'd1) begin n_fail++; $display("FAIL rtype_cnt: got %0d expected 1", instr_cnt); end
    endtask

    task automatic test_lw_stall();
        logic [3:0]  exp_st  [0:9];
        logic [15:0] exp_ctl [0:9];
        logic        rdy     [0:9];
        exp_st  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};
        exp_ctl = '{16'h1010, 16'h1010, 16'h1010, 16'h9410, 16'h0030,
                    16'h0060, 16'h3000, 16'h3000, 16'h3000, 16'h0280};
        rdy     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            mem_ready = rdy[i];
            // After DECODE the IR input shows sw; the latched lw must still steer to MEMRD.
            opcode = (i <= 4) ? 6'h23 : 6'h2B;
            #1;
            n_checks++;
            if (state !== exp_st[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
            n_checks++;
            if (ctl !== exp_ctl[i]) begin n_fail++; $display("FAIL lw_ctl[%0d]: got %h expected %h", i, ctl, exp_ctl[i]); end
            cyc();
        end
        mem_ready = 1'b1; #1;
        n_checks++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL lw_end_state: got %0d expected 1", state); end
        n_checks++;
        if (instr_cnt !== 4'd2) begin n_fail++; $display("FAIL lw_cnt: got %0d expected 2", instr_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_st  [0:9];
        logic [15:0] exp_ctl [0:9];
        logic [5:0]  op      [0:9];
        exp_st  = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd10};
        exp_ctl = '{16'h9410, 16'h0030, 16'h0060, 16'h2800, 16'h9410,
                    16'h0030, 16'h4045, 16'h9410, 16'h0030, 16'h8002};
        op      = '{6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h04, 6'h04, 6'h04, 6'h02, 6'h02, 6'h02};
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'b1; opcode = op[i]; #1;
            n_checks++;
            if (state !== exp_st[i]) begin n_fail++; $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
            n_checks++;
            if (ctl !== exp_ctl[i]) begin n_fail++; $display("FAIL b2b_ctl[%0d]: got %h expected %h", i, ctl, exp_ctl[i]); end
            cyc();
        end
        #1;
        n_checks++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL b2b_end_state: got %0d expected 1", state); end
        n_checks++;
        if (instr_cnt !== 4'd5) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 5", instr_cnt); end
    endtask

    task automatic test_illegal();
        logic [3:0]  exp_st  [0:4];
        logic [15:0] exp_ctl [0:4];
        logic [5:0]  op      [0:4];
        logic        exp_ill [0:4];
        exp_st  = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd10};
        exp_ctl = '{16'h9410, 16'h0030, 16'h9410, 16'h0030, 16'h8002};
        op      = '{6'h3F, 6'h3F, 6'h02, 6'h02, 6'h02};
        exp_ill = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1; opcode = op[i]; #1;
            n_checks++;
            if (state !== exp_st[i]) begin n_fail++; $display("FAIL ill_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
            n_checks++;
            if (ctl !== exp_ctl[i]) begin n_fail++; $display("FAIL ill_ctl[%0d]: got %h expected %h", i, ctl, exp_ctl[i]); end
            n_checks++;
            if (illegal !== exp_ill[i]) begin n_fail++; $display("FAIL ill_flag[%0d]: got %b expected %b", i, illegal, exp_ill[i]); end
            if (i == 2) begin
                n_checks++;
                if (instr_cnt !== 4'd5) begin n_fail++; $display("FAIL ill_cnt_held: got %0d expected 5", instr_cnt); end
            end
            cyc();
        end
        #1;
        n_checks++;
        if (instr_cnt !== 4'd6) begin n_fail++; $display("FAIL ill_end_cnt: got %0d expected 6", instr_cnt); end
    endtask

    task automatic test_reset_mid_memrd();
        logic [3:0]  exp_st  [0:3];
        logic [15:0] exp_ctl [0:3];
        exp_st  = '{4'd1, 4'd2, 4'd3, 4'd4};
        exp_ctl = '{16'h9410, 16'h0030, 16'h0060, 16'h3000};
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3) ? 1'b0 : 1'b1;
            opcode    = 6'h23;
            rst       = (i == 3);
            #1;
            n_checks++;
            if (state !== exp_st[i]) begin n_fail++; $display("FAIL rstmid_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); end
            n_checks++;
            if (ctl !== exp_ctl[i]) begin n_fail++; $display("FAIL rstmid_ctl[%0d]: got %h expected %h", i, ctl, exp_ctl[i]); end
            cyc();
        end
        #1;
        n_checks++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL rstmid_state_rst: got %0d expected 0", state); end
        n_checks++;
        if (ctl !== 16'h0000) begin n_fail++; $display("FAIL rstmid_ctl_rst: got %h expected 0000", ctl); end
        n_checks++;
        if (instr_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", instr_cnt); end
        rst = 1'b0;
        cyc(); #1;
        n_checks++;
        if (state !== 4'd1) begin n_fail++; $display("FAIL rstmid_fetch: got %0d expected 1", state); end
        n_checks++;
        if (ctl !== 16'h1010) begin n_fail++; $display("FAIL rstmid_fetch_ctl: got %h expected 1010", ctl); end
    endtask

    task automatic test_cnt_wrap();
        logic [3:0]  exp_st  [0:3];
        logic [15:0] exp_ctl [0:3];
        logic [3:0]  exp_cnt;
        exp_st  = '{4'd1, 4'd2, 4'd11, 4'd12};
        exp_ctl = '{16'h9410, 16'h0030, 16'h0060, 16'h0080};
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 4; j++) begin
                mem_ready = 1'b1; opcode = 6'h08; #1;
                n_checks++;
                if (state !== exp_st[j]) begin n_fail++; $display("FAIL wrap_state[%0d.%0d]: got %0d expected %0d", k, j, state, exp_st[j]); end
                n_checks++;
                if (ctl !== exp_ctl[j]) begin n_fail++; $display("FAIL wrap_ctl[%0d.%0d]: got %h expected %h", k, j, ctl, exp_ctl[j]); end
                cyc();
            end
            #1;
            exp_cnt = 4'(k + 1);
            n_checks++;
            if (instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", k, instr_cnt, exp_cnt); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_back_to_back();
        test_illegal();
        test_reset_mid_memrd();
        test_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and writeback over several cycles. Per state, it drives the datapath enables and the 2-bit ALUop consumed by the ALU control decoder. Memory accesses use a ready handshake, so the FSM stalls on slow memory. It also counts retired instructions and flags unsupported opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter
ST_W, 4, width of state/debug output

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  IR[31:26], sampled in DECODE
mem_ready  in  1  memory completes current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero (beq)
IorD  out  1  0=PC addresses memory, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load instruction register
MemtoReg  out  1  0=ALUOut, 1=MDR to register write data
RegDst  out  1  0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUop  out  2  00=add, 01=sub (beq), 10=R-type funct
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
state  out  ST_W  current state encoding (debug)
instr_cnt  out  CNT_W  retired instructions
illegal  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- State encodings: S_RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12.
- Moore outputs decoded from the state register. Any output not listed for a state is 0.
- rst=1 at a clock edge: state<=S_RST, instr_cnt<=0, illegal<=0. This applies mid-instruction too; an in-flight memory request is abandoned.
- In S_RST every output is 0. The state is held for exactly one cycle after rst deasserts, then FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00. IRWrite=PCWrite=mem_ready (combinationally gated).
  - Stay in FETCH while mem_ready=0.
  - Go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - other -> FETCH, with illegal=1 for the next cycle only; instr_cnt does not increment.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Wait for mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10. Next state ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next state ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
- The opcode that steers the MEMADR branch is latched in DECODE, so it does not track the IR input afterwards.
- instr_cnt increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB. It wraps modulo 2^CNT_W.
- Cycle counts with mem_ready constantly 1:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Unused state encodings go to S_RST on the next edge.

Test Plan:
- Reset then release, mem_ready=1, opcode=000000 -> state sequence 0,1,2,7,8,1. RegWrite=1 and RegDst=1 only in state 8. instr_cnt=1 on return to FETCH.
- lw (100011) with mem_ready low 3 cycles in FETCH and 2 in MEMRD -> FETCH held 4 cycles with IRWrite/PCWrite=0 until the ready cycle. MEMRD held 3 cycles. MEMWB asserts RegWrite=1 and MemtoReg=1. Total 10 cycles FETCH-to-FETCH.
- sw (101011) then beq (000100) then j (000010), mem_ready=1 -> MemWrite=1 and IorD=1 for one cycle. BRANCH gives ALUop=01, PCWriteCond=1, PCSource=01. JUMP gives PCWrite=1, PCSource=10. instr_cnt advances 0->3.
- Opcode 111111 in DECODE -> next state FETCH, illegal=1 for exactly one cycle, instr_cnt unchanged.
- rst asserted during MEMRD with mem_ready=0 -> next cycle state=0 with all outputs 0 and instr_cnt=0. FETCH follows one cycle after rst drops.
- Force instr_cnt near max (CNT_W=4, run 16 addi) -> count wraps 15->0 with no stall.
